// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
// Segment bytes are active-low: bits[7:1] = a..g, bit0 = dp.
package display_pkg;

   typedef logic [7:0] seg_t;

   localparam seg_t SEG_BLANK = 8'hFF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

endpackage : display_pkg

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner: blank gap then dwell per digit,
// with a double-buffered segment/enable store that only swaps at frame wrap.
module display_scanner
   import display_pkg::*;
#(
   parameter int N_DIGITS     = 8,
   parameter int DWELL_CYCLES = 12500,
   parameter int BLANK_CYCLES = 250
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [8*N_DIGITS-1:0]   seg_i,
   input  logic [N_DIGITS-1:0]     en_i,
   input  logic                    load_i,
   output logic [N_DIGITS-1:0]     an_o,
   output seg_t                    seg_o,
   output logic                    frame_o,
   output logic                    pend_o
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(N_DIGITS);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

   scan_state_t              r_state;
   scan_state_t              w_state_nxt;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         w_cnt_nxt;
   logic [IDX_W-1:0]         r_idx;
   logic [IDX_W-1:0]         w_idx_nxt;
   logic                     w_wrap;

   logic [8*N_DIGITS-1:0]    r_act_seg;
   logic [N_DIGITS-1:0]      r_act_en;
   logic [8*N_DIGITS-1:0]    r_pend_seg;
   logic [N_DIGITS-1:0]      r_pend_en;
   logic                     r_pend;

   seg_t                     w_cur_seg;
   logic                     w_cur_en;
   logic [N_DIGITS-1:0]      w_an_nxt;
   seg_t                     w_seg_nxt;

   logic [N_DIGITS-1:0]      r_an;
   seg_t                     r_seg;
   logic                     r_wrap_d;
   logic                     r_frame;

   // Scan state, slot counter and digit index
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next-state logic; w_wrap marks the last DRIVE cycle of the final digit
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_idx_nxt   = r_idx;
      w_wrap      = 1'b0;
      case (r_state)
         ST_BLANK: begin
            if (r_cnt == BLANK_LAST) begin
               w_state_nxt = ST_DRIVE;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = ST_BLANK;
            end
         end
         ST_DRIVE: begin
            if (r_cnt == DWELL_LAST) begin
               w_state_nxt = ST_BLANK;
               w_cnt_nxt   = '0;
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt = '0;
                  w_wrap    = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end else begin
               w_state_nxt = ST_DRIVE;
            end
         end
         default: begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Double buffer: active only changes on the wrap edge, so a frame never tears
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_act_seg  <= {N_DIGITS{SEG_BLANK}};
         r_act_en   <= '0;
         r_pend_seg <= {N_DIGITS{SEG_BLANK}};
         r_pend_en  <= '0;
         r_pend     <= 1'b0;
      end else if (w_wrap) begin
         if (load_i) begin
            r_act_seg <= seg_i;
            r_act_en  <= en_i;
         end else if (r_pend) begin
            r_act_seg <= r_pend_seg;
            r_act_en  <= r_pend_en;
         end
         r_pend <= 1'b0;
      end else if (load_i) begin
         r_pend_seg <= seg_i;
         r_pend_en  <= en_i;
         r_pend     <= 1'b1;
      end
   end

   assign w_cur_seg = r_act_seg[{r_idx, 3'b000} +: 8];
   assign w_cur_en  = r_act_en[r_idx];

   // Drive values for the current digit; dark during blanking or when disabled
   always_comb begin
      w_an_nxt  = '1;
      w_seg_nxt = SEG_BLANK;
      if ((r_state == ST_DRIVE) && w_cur_en) begin
         w_an_nxt  = ~(N_DIGITS'(1) << r_idx);
         w_seg_nxt = w_cur_seg;
      end else begin
         w_an_nxt  = '1;
         w_seg_nxt = SEG_BLANK;
      end
   end

   // Output registers; frame pulse is delayed twice to line up with the dark gap of digit 0
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_an     <= '1;
         r_seg    <= SEG_BLANK;
         r_wrap_d <= 1'b0;
         r_frame  <= 1'b0;
      end else begin
         r_an     <= w_an_nxt;
         r_seg    <= w_seg_nxt;
         r_wrap_d <= w_wrap;
         r_frame  <= r_wrap_d;
      end
   end

   assign an_o    = r_an;
   assign seg_o   = r_seg;
   assign frame_o = r_frame;
   assign pend_o  = r_pend;

endmodule : display_scanner
